// File: rtl/instr_seq_ctrl.sv
// Program-memory instruction sequencer: streams a CPU-loaded program num_rounds
// times to the experiment FSM and runs its trigger/halt/done handshake.
module instr_seq_ctrl #(
  parameter int PROG_DEPTH   = 256,
  parameter int AW           = $clog2(PROG_DEPTH),
  parameter int TRIG_TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_prog_wr_en,
  input  logic [AW-1:0] i_prog_wr_addr,
  input  logic [15:0]   i_prog_wr_data,
  input  logic [AW:0]   i_prog_len,
  input  logic [15:0]   i_num_rounds,
  input  logic          i_start,
  input  logic          i_abort,
  output logic [15:0]   o_instr_axis_tdata,
  output logic          o_instr_axis_tvalid,
  input  logic          i_instr_axis_tready,
  output logic          o_run_trig,
  input  logic          i_run_done,
  output logic          o_halt,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_aborted,
  output logic          o_err,
  output logic [15:0]   o_round_cnt
);

  localparam int TW = $clog2(TRIG_TIMEOUT + 2);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_STREAM, S_DRAIN, S_WAIT} state_t;

  logic [15:0]   r_mem [PROG_DEPTH];
  logic [15:0]   r_rdata;
  state_t        r_state, w_state_next;
  logic [AW-1:0] r_ptr, w_ptr_next;
  logic [AW:0]   r_len, w_len_next;
  logic [15:0]   r_rounds, w_rounds_next;
  logic [15:0]   r_round_cnt, w_round_cnt_next;
  logic [TW-1:0] r_tcnt, w_tcnt_next;
  logic          r_abort_pend, w_abort_pend_next;
  logic          r_done, w_done_next;
  logic          r_aborted, w_aborted_next;
  logic          r_err, w_err_next;

  logic w_hs, w_last_word, w_last_round, w_final_hs, w_start_ok;

  assign w_hs         = (r_state == S_STREAM) && i_instr_axis_tready;
  assign w_last_word  = ({1'b0, r_ptr} == (r_len - (AW+1)'(1)));
  assign w_last_round = (r_round_cnt == (r_rounds - 16'd1));
  assign w_final_hs   = w_hs && w_last_word && w_last_round;
  assign w_start_ok   = (r_state == S_IDLE) && i_start && i_run_done;

  always_comb begin
    w_state_next      = r_state;
    w_len_next        = r_len;
    w_rounds_next     = r_rounds;
    w_round_cnt_next  = r_round_cnt;
    w_tcnt_next       = r_tcnt;
    w_abort_pend_next = r_abort_pend;
    w_done_next       = r_done;
    w_aborted_next    = r_aborted;
    w_err_next        = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_len_next        = i_prog_len;
          w_rounds_next     = i_num_rounds;
          w_round_cnt_next  = '0;
          w_tcnt_next       = '0;
          w_abort_pend_next = 1'b0;
          w_aborted_next    = 1'b0;
          w_err_next        = 1'b0;
          if (i_prog_len == '0 || i_num_rounds == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_done_next  = 1'b0;
            w_state_next = S_TRIG;
          end
        end
      end
      S_TRIG: begin
        if (i_abort) w_abort_pend_next = 1'b1;
        if (!i_run_done) begin
          w_state_next = S_STREAM;
        end else if (r_tcnt == TW'(TRIG_TIMEOUT)) begin
          w_err_next   = 1'b1;
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_tcnt_next = r_tcnt + TW'(1);
        end
      end
      S_STREAM: begin
        if (w_hs && w_last_word && r_round_cnt != 16'hFFFF)
          w_round_cnt_next = r_round_cnt + 16'd1;
        if (w_final_hs) begin
          w_state_next = S_DRAIN;
        end else if (i_abort || r_abort_pend) begin
          // The pending flag doubles as the "abort was taken" record.
          w_abort_pend_next = 1'b1;
          w_state_next      = S_DRAIN;
        end
      end
      S_DRAIN: w_state_next = S_WAIT;
      S_WAIT: begin
        if (i_run_done) begin
          w_done_next    = 1'b1;
          w_aborted_next = r_abort_pend;
          w_state_next   = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (i_prog_wr_en && r_state != S_IDLE) w_err_next = 1'b1;
  end

  // Read address is the next pointer, so the registered read always holds prog[r_ptr].
  always_comb begin
    w_ptr_next = '0;
    if (r_state == S_STREAM) begin
      if (w_hs) w_ptr_next = w_last_word ? '0 : r_ptr + AW'(1);
      else      w_ptr_next = r_ptr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_prog_wr_en && r_state == S_IDLE) r_mem[i_prog_wr_addr] <= i_prog_wr_data;
    r_rdata <= r_mem[w_ptr_next];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_len        <= '0;
      r_rounds     <= '0;
      r_round_cnt  <= '0;
      r_tcnt       <= '0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ptr        <= w_ptr_next;
      r_len        <= w_len_next;
      r_rounds     <= w_rounds_next;
      r_round_cnt  <= w_round_cnt_next;
      r_tcnt       <= w_tcnt_next;
      r_abort_pend <= w_abort_pend_next;
      r_done       <= w_done_next;
      r_aborted    <= w_aborted_next;
      r_err        <= w_err_next;
    end
  end

  assign o_instr_axis_tvalid = (r_state == S_STREAM);
  assign o_instr_axis_tdata  = o_instr_axis_tvalid ? r_rdata : 16'h0000;
  assign o_run_trig          = (r_state == S_TRIG);
  assign o_halt              = (r_state == S_DRAIN) || (r_state == S_WAIT);
  assign o_busy              = (r_state != S_IDLE);
  assign o_done              = r_done;
  assign o_aborted           = r_aborted;
  assign o_err               = r_err;
  assign o_round_cnt         = r_round_cnt;

endmodule

// File: doc/instr_seq_ctrl.md
# instr_seq_ctrl

Program-memory instruction sequencer that drives the experiment FSM's 16-bit instruction stream and its run handshake. The CPU loads a program of up to `PROG_DEPTH` instruction words. On `start`, the block triggers a run, streams the program `num_rounds` times back-to-back, then asserts `halt` and waits for the FSM to report completion. It sits between the CPU register bus and the experiment FSM, replacing direct CPU pushes into the instruction AXIS bus.

## Interface
- `PROG_DEPTH`, 256 — program memory depth in 16-bit words; power of two.
- `AW`, $clog2(PROG_DEPTH) — program address width.
- `TRIG_TIMEOUT`, 255 — cycles allowed for `run_done` to fall after `run_trig`.
- `clk`  in  1  — sole clock.
- `rst`  in  1  — synchronous, active-high reset.
- `prog_wr_en`  in  1  — CPU program write strobe.
- `prog_wr_addr`  in  AW  — program write address.
- `prog_wr_data`  in  16  — instruction word.
- `prog_len`  in  AW+1  — instructions per round, 0..PROG_DEPTH; latched on start.
- `num_rounds`  in  16  — round count; latched on start.
- `start`  in  1  — level; sampled only in IDLE.
- `abort`  in  1  — level; stops streaming early.
- `instr_axis_tdata`  out  16  — instruction to the experiment FSM.
- `instr_axis_tvalid`  out  1  — instruction valid.
- `instr_axis_tready`  in  1  — from the experiment FSM.
- `run_trig`  out  1  — run trigger to the experiment FSM.
- `run_done`  in  1  — FSM done flag; high when the FSM is idle.
- `halt`  out  1  — tells the FSM to finish once tvalid is low.
- `busy`  out  1  — high in any state other than IDLE.
- `done`  out  1  — sticky; set on completion, cleared on the next accepted start.
- `aborted`  out  1  — sticky; set when completion was caused by abort.
- `err`  out  1  — sticky; set by trigger timeout or by a program write while busy. Cleared on accepted start.
- `round_cnt`  out  16  — rounds fully streamed so far.

## Operation
- All outputs reset to 0. Reset also forces IDLE and clears the read pointer.
- Program memory contents are not reset.
- **Program writes**
  - Accepted only in IDLE.
  - A write while `busy` is dropped and sets `err`.
  - Synchronous-read memory; the block must still sustain one instruction per cycle.
- **IDLE**
  - Start is accepted when `start` && `run_done`. On acceptance: latch `prog_len` and `num_rounds`, clear `done`, `aborted`, `err` and `round_cnt`.
  - If `prog_len`==0 or `num_rounds`==0, set `done` next cycle and stay in IDLE; no `run_trig`.
  - Otherwise go to TRIG.
  - `start` while `run_done`=0 is ignored.
- **TRIG**
  - `run_trig`=1, `halt`=0, tvalid=0. Wait for `run_done`=0, then drop `run_trig` and go to STREAM.
  - If `run_done` stays high for `TRIG_TIMEOUT`+1 cycles: set `err`, drop `run_trig`, return to IDLE with `done`=1.
  - `abort` in TRIG is remembered and applied on entry to STREAM.
- **STREAM**
  - tvalid=1; tdata = prog[ptr].
  - On each handshake (tvalid && tready), advance `ptr`.
  - When `ptr`==`prog_len`-1 is consumed: wrap `ptr` to 0 and increment `round_cnt`.
  - When the last word of the last round is consumed, go to DRAIN.
  - tdata must be stable while tvalid && !tready.
- **DRAIN**
  - tvalid=0 and `halt`=1, registered outputs on the cycle after the final handshake or after `abort` is sampled.
  - Go to WAIT_DONE.
- **WAIT_DONE**
  - Hold `halt`=1 until `run_done`=1.
  - Then `halt`=0, `done`=1, `aborted` = (abort was taken), and go to IDLE.
- `abort` in STREAM takes effect on the next edge. A handshake occurring in that same cycle still counts.
- `round_cnt` saturates at 0xFFFF; it cannot overflow because `num_rounds` is also 16 bits.

## Timing
- `start` sampled at edge N gives `run_trig`=1 after edge N.
- The first `run_done`=0 seen at edge M gives `run_trig`=0 and tvalid=1 with prog[0] after edge M.
- Throughput is 1 word/cycle while tready=1, including across round wrap. There are no bubbles between rounds.
- Final handshake at edge K gives tvalid=0 and `halt`=1 after K.
- `run_done`=1 sampled at edge J gives `halt`=0, `done`=1 and `busy`=0 after J.
- `rst` asserted at any point returns all outputs to 0 on the next edge, including mid-stream.

## Test plan
- **Basic stream.** prog={0x0001,0x0002,0x0004}, `prog_len`=3, `num_rounds`=2, tready=1 from the first cycle of STREAM. Required: tdata 1,2,4,1,2,4 on 6 consecutive cycles, `round_cnt`=2, `halt` high the cycle after the sixth word. After a modelled FSM raises `run_done`: `done`=1, `halt`=0.
- **Backpressure.** Same program, tready pseudo-random 50%. Required: tdata stable while stalled, exactly 6 handshakes, order unchanged, no duplicates.
- **Degenerate lengths.** `prog_len`=0, then `num_rounds`=0. Required: `run_trig` never asserted, `done`=1 one cycle after start, `err`=0.
- **Abort.** Abort asserted after the 4th handshake of `prog_len`=8, `num_rounds`=4. Required: tvalid low next cycle, `halt`=1, `round_cnt`=0. Once `run_done` rises: `done`=1, `aborted`=1.
- **Trigger timeout.** `run_done` held high after start. Required: `run_trig` high 256 cycles, then `err`=1, `done`=1, `busy`=0.
- **Illegal write and mid-stream reset.** A program write during STREAM sets `err`, and a rerun shows the old word. `rst` mid-stream gives all outputs 0 next cycle; a new start works normally.
